// File: rtl/gate_check_pkg.sv
// gate_check_pkg: shared types and constants for the gate-block checkers.
//   state_t       checker FSM states
//   *_BIT         bit positions of each gate output inside gate_vec
//   NUM_GATES     width of gate_vec
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_GATES = 7;

  localparam int AND_BIT  = 6;
  localparam int OR_BIT   = 5;
  localparam int NOT_BIT  = 4;
  localparam int XOR_BIT  = 3;
  localparam int NAND_BIT = 2;
  localparam int NOR_BIT  = 1;
  localparam int XNOR_BIT = 0;

endpackage

// File: rtl/gate_vector_checker_if.sv
// gate_vector_checker_if: stimulus/response and status bundle of the checker.
//   start          run request (towards checker)
//   A, B           stimulus driven into the gate block
//   gate_vec       gate block outputs (towards checker)
//   busy, done     run in progress / end-of-run pulse
//   pass           result of the last run
//   err_count      saturating count of failing vectors (ERR_W bits)
//   fail_mask      OR of per-gate mismatches over the run
//   first_fail_idx {A,B} of the first failing vector
// modport slave is the checker side, master is the side that starts runs
// and hosts the gate block.
interface gate_vector_checker_if #(
  parameter int ERR_W = 8
) ();

  logic                                 start;
  logic                                 A;
  logic                                 B;
  logic [gate_check_pkg::NUM_GATES-1:0] gate_vec;
  logic                                 busy;
  logic                                 done;
  logic                                 pass;
  logic [ERR_W-1:0]                     err_count;
  logic [gate_check_pkg::NUM_GATES-1:0] fail_mask;
  logic [1:0]                           first_fail_idx;

  modport slave (
    input  start,
    input  gate_vec,
    output A,
    output B,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_mask,
    output first_fail_idx
  );

  modport master (
    output start,
    output gate_vec,
    input  A,
    input  B,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_mask,
    input  first_fail_idx
  );

endinterface

// File: rtl/gate_golden_model.sv
// gate_golden_model: combinational reference for the basic two-input gate
// block, usable by any checker that needs the expected gate outputs.
//   i_a, i_b  gate inputs
//   o_exp     expected outputs, ordered by the *_BIT constants
module gate_golden_model
  import gate_check_pkg::*;
(
  input  logic                 i_a,
  input  logic                 i_b,
  output logic [NUM_GATES-1:0] o_exp
);

  always_comb begin
    o_exp           = '0;
    o_exp[AND_BIT]  = i_a & i_b;
    o_exp[OR_BIT]   = i_a | i_b;
    o_exp[NOT_BIT]  = ~i_a;
    o_exp[XOR_BIT]  = i_a ^ i_b;
    o_exp[NAND_BIT] = ~(i_a & i_b);
    o_exp[NOR_BIT]  = ~(i_a | i_b);
    o_exp[XNOR_BIT] = ~(i_a ^ i_b);
  end

endmodule

// File: rtl/gate_vector_checker.sv
// gate_vector_checker: clocked built-in self test for the two-input gate
// block. Steps {A,B} through 00,01,10,11 (LOOPS times), holds each vector
// SETTLE_CYCLES cycles, samples gate_vec, compares it with the golden model
// and accumulates err_count / fail_mask / first_fail_idx.
//   clk, rst_n  clock, asynchronous active-low reset
//   io_chk      slave modport: start in, A/B out, gate_vec in, status out
// Build option: GVC_STOP_ON_FAIL_EN ends the run at the first failing sample.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// SETTLE | current {A,B} applied, counting the settle window
// SAMPLE | compare gate_vec with golden, advance vector or finish
// DONE   | one-cycle done pulse, pass valid
module gate_vector_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_vector_checker_if.slave io_chk
);
  import gate_check_pkg::*;

  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES);
  localparam logic [15:0] LAST_LOOP   = 16'(LOOPS - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_a;
  logic                   r_b;
  logic [3:0]             r_settle_cnt;
  logic [15:0]            r_loop_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pass;
  logic [ERR_W-1:0]       r_err_count;
  logic [NUM_GATES-1:0]   r_fail_mask;
  logic [1:0]             r_first_fail_idx;

  logic [NUM_GATES-1:0]   w_golden;
  logic [NUM_GATES-1:0]   w_mism;
  logic [3:0]             w_settle_inc;
  logic                   w_last_vec;
  logic                   w_loops_left;

  gate_golden_model u_golden (
    .i_a   (r_a),
    .i_b   (r_b),
    .o_exp (w_golden)
  );

  assign w_mism       = io_chk.gate_vec ^ w_golden;
  assign w_settle_inc = r_settle_cnt + 4'd1;
  assign w_last_vec   = r_a & r_b;
  assign w_loops_left = (r_loop_cnt != LAST_LOOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (io_chk.start) w_next_state = SETTLE;
      end
      SETTLE: begin
        if (w_settle_inc == SETTLE_LAST) w_next_state = SAMPLE;
      end
      SAMPLE: begin
        if (!w_last_vec || w_loops_left) w_next_state = SETTLE;
        else                             w_next_state = DONE;
`ifdef GVC_STOP_ON_FAIL_EN
        if (w_mism != '0) w_next_state = DONE;
`endif
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Status outputs are registered off the next state so busy/done line up
  // exactly with the cycles spent in SETTLE/SAMPLE and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a              <= 1'b0;
      r_b              <= 1'b0;
      r_settle_cnt     <= '0;
      r_loop_cnt       <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_count      <= '0;
      r_fail_mask      <= '0;
      r_first_fail_idx <= '0;
    end else begin
      r_busy <= (w_next_state == SETTLE) || (w_next_state == SAMPLE);
      r_done <= (w_next_state == DONE);
      case (r_state)
        IDLE: begin
          if (io_chk.start) begin
            r_a              <= 1'b0;
            r_b              <= 1'b0;
            r_settle_cnt     <= '0;
            r_loop_cnt       <= '0;
            r_pass           <= 1'b0;
            r_err_count      <= '0;
            r_fail_mask      <= '0;
            r_first_fail_idx <= '0;
          end
        end
        SETTLE: begin
          r_settle_cnt <= w_settle_inc;
        end
        SAMPLE: begin
          r_settle_cnt <= '0;
          r_fail_mask  <= r_fail_mask | w_mism;
          if (w_mism != '0) begin
            if (r_err_count != '1) r_err_count <= r_err_count + ERR_W'(1);
            // err_count never returns to zero within a run, so zero means
            // this is the first failing vector.
            if (r_err_count == '0) r_first_fail_idx <= {r_a, r_b};
          end
          if (w_next_state == SETTLE) begin
            {r_a, r_b} <= {r_a, r_b} + 2'd1;
            if (w_last_vec) r_loop_cnt <= r_loop_cnt + 16'd1;
          end
          if (w_next_state == DONE) begin
            r_pass <= (w_mism == '0) && (r_err_count == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_chk.A              = r_a;
  assign io_chk.B              = r_b;
  assign io_chk.busy           = r_busy;
  assign io_chk.done           = r_done;
  assign io_chk.pass           = r_pass;
  assign io_chk.err_count      = r_err_count;
  assign io_chk.fail_mask      = r_fail_mask;
  assign io_chk.first_fail_idx = r_first_fail_idx;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: three checker instances with different
// SETTLE_CYCLES/LOOPS, each wrapped around a gate block model whose faults
// are a per-vector table of flipped outputs. Expected run results come from
// a truth-table walk in the bench and are queued at start; a monitor pops
// and compares them on every done pulse.
module tb_gate_vector_checker;

  localparam int S_P [3] = '{2, 1, 1};
  localparam int L_P [3] = '{1, 2, 300};
  localparam int ERR_MAX = 255;

  typedef struct {
    logic       pass;
    int         err;
    logic [6:0] mask;
    logic [1:0] idx;
    logic [1:0] ab_end;
    int         busy;
    int         t0;
  } exp_t;

  logic       clk;
  logic       rst_n;
  int         cyc = 0;
  int         n_checks;
  int         n_fail;

  logic       start_v [3];
  logic [6:0] flip    [3][4];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       pass_v  [3];
  logic [7:0] err_v   [3];
  logic [6:0] mask_v  [3];
  logic [1:0] idx_v   [3];
  logic [1:0] ab_v    [3];

  exp_t       exp_q   [3][$];
  int         busy_cnt [3];
  int         ab_bad   [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] ref_gates(input logic a, input logic b);
    return {a & b, a | b, ~a, a ^ b, ~(a & b), ~(a | b), ~(a ^ b)};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gate_vector_checker_if #(.ERR_W(8)) bus ();

    gate_vector_checker #(
      .SETTLE_CYCLES (S_P[g]),
      .LOOPS         (L_P[g]),
      .ERR_W         (8)
    ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_chk (bus)
    );

    assign bus.start    = start_v[g];
    assign bus.gate_vec = ref_gates(bus.A, bus.B) ^ flip[g][{bus.A, bus.B}];
    assign busy_v[g]    = bus.busy;
    assign done_v[g]    = bus.done;
    assign pass_v[g]    = bus.pass;
    assign err_v[g]     = bus.err_count;
    assign mask_v[g]    = bus.fail_mask;
    assign idx_v[g]     = bus.first_fail_idx;
    assign ab_v[g]      = {bus.A, bus.B};
  end

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s dut%0d: actual %0d, expected %0d", nm, k, act, expv);
    end
  endtask

  // Walk the truth table as the run would: a vector fails when any output
  // differs from the ideal gate, i.e. when its fault table entry is nonzero.
  function automatic exp_t model(input int k);
    exp_t e;
    int   vecs;
    bit   stop;
    logic [6:0] m;
    e.pass = 1'b0; e.err = 0; e.mask = '0; e.idx = '0; e.ab_end = '0;
    e.t0 = 0; vecs = 0; stop = 1'b0;
    for (int l = 0; l < L_P[k] && !stop; l++) begin
      for (int v = 0; v < 4 && !stop; v++) begin
        m = flip[k][v];
        vecs++;
        e.ab_end = 2'(v);
        if (m != 7'h00) begin
          if (e.err == 0) e.idx = 2'(v);
          if (e.err < ERR_MAX) e.err++;
          e.mask |= m;
`ifdef GVC_STOP_ON_FAIL_EN
          stop = 1'b1;
`endif
        end
      end
    end
    e.pass = (e.err == 0);
    e.busy = vecs * (S_P[k] + 1);
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        busy_cnt[k] = 0;
        ab_bad[k]   = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (busy_v[k] === 1'b1) begin
          if (ab_v[k] !== 2'((busy_cnt[k] / (S_P[k] + 1)) % 4)) ab_bad[k]++;
          busy_cnt[k]++;
        end
        if (done_v[k] === 1'b1) begin
          if (exp_q[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done dut%0d: actual done=1, expected done=0", k);
          end else begin
            e = exp_q[k].pop_front();
            check("latency",        k, cyc - e.t0,   e.busy + 1);
            check("busy_cycles",    k, busy_cnt[k],  e.busy);
            check("busy_at_done",   k, busy_v[k],    0);
            check("pass",           k, pass_v[k],    e.pass);
            check("err_count",      k, err_v[k],     e.err);
            check("fail_mask",      k, mask_v[k],    e.mask);
            check("first_fail_idx", k, idx_v[k],     e.idx);
            check("ab_end",         k, ab_v[k],      e.ab_end);
            check("ab_sequence",    k, ab_bad[k],    0);
          end
          busy_cnt[k] = 0;
          ab_bad[k]   = 0;
        end
      end
    end
  end

  task automatic drain(input int k);
    int t;
    t = 0;
    while (exp_q[k].size() != 0 && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q[k].size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout dut%0d: actual no done in %0d cycles, expected done", k, t);
      exp_q[k].delete();
    end
  endtask

  task automatic run(input int k, input bit extra_start);
    exp_t e;
    e = model(k);
    @(negedge clk);
    start_v[k] = 1'b1;
    e.t0 = cyc;
    exp_q[k].push_back(e);
    @(negedge clk);
    start_v[k] = 1'b0;
    if (extra_start) begin
      repeat (3) @(negedge clk);
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
    end
    drain(k);
    repeat (3) @(negedge clk);
    check("pass_hold", k, pass_v[k], e.pass);
    check("idle_busy", k, busy_v[k], 0);
  endtask

  // start raised during the done cycle and held one more cycle: only the
  // second cycle (back in IDLE) may launch the next run.
  task automatic across_done(input int k);
    exp_t e;
    int   t;
    e = model(k);
    @(negedge clk);
    start_v[k] = 1'b1;
    e.t0 = cyc;
    exp_q[k].push_back(e);
    @(negedge clk);
    start_v[k] = 1'b0;
    t = 0;
    while (done_v[k] !== 1'b1 && t < 6000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", k, done_v[k], 1);
    start_v[k] = 1'b1;
    @(negedge clk);
    e.t0 = cyc;
    exp_q[k].push_back(e);
    @(negedge clk);
    start_v[k] = 1'b0;
    drain(k);
  endtask

  task automatic reset_abort();
    int t;
    flip[0][0] = 7'h40;
    flip[0][1] = 7'h01;
    flip[0][2] = 7'h00;
    flip[0][3] = 7'h00;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    t = 0;
    while (ab_v[0] !== 2'b10 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("pre_reset_ab",  0, ab_v[0],  2'b10);
    check("pre_reset_err", 0, err_v[0], 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ab",   0, ab_v[0],   0);
    check("rst_busy", 0, busy_v[0], 0);
    check("rst_done", 0, done_v[0], 0);
    check("rst_pass", 0, pass_v[0], 0);
    check("rst_err",  0, err_v[0],  0);
    check("rst_mask", 0, mask_v[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 4; v++) flip[0][v] = 7'h00;
    repeat (20) @(negedge clk);
    run(0, 1'b0);
  endtask

  initial begin : stim
    int k;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      for (int v = 0; v < 4; v++) flip[i][v] = 7'h00;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_ab",   i, ab_v[i],   0);
      check("reset_busy", i, busy_v[i], 0);
      check("reset_done", i, done_v[i], 0);
      check("reset_pass", i, pass_v[i], 0);
      check("reset_err",  i, err_v[i],  0);
      check("reset_mask", i, mask_v[i], 0);
      check("reset_idx",  i, idx_v[i],  0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run(0, 1'b0);

    flip[0][1] = 7'b0001000;
    flip[0][2] = 7'b0001000;
    run(0, 1'b0);

    for (int v = 0; v < 4; v++) flip[0][v] = 7'h00;
    run(0, 1'b1);

    flip[0][3] = 7'h22;
    across_done(0);

    reset_abort();

    run(1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      k = int'($urandom_range(0, 1));
      for (int v = 0; v < 4; v++)
        flip[k][v] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
      run(k, 1'b0);
    end

    for (int v = 0; v < 4; v++) flip[2][v] = 7'h7F;
    run(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
